// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and types for the SR-1 memory access controller.
// The optional 16-bit access path is selected with the MEM_WORD_EN macro.
package sr1_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] MM_PRESCALE = 15'h7FFF;
    localparam logic [ADDR_W-1:0] MM_SW1      = 15'h7FFE;
    localparam logic [ADDR_W-1:0] MM_SW2      = 15'h7FFD;
    localparam logic [ADDR_W-1:0] MM_BTN1     = 15'h7FFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic              write;
        logic              word;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response and byte-memory bus bundle for mem_access_ctrl.
// master = the controller, slave = the core plus memory responder.
interface mem_access_ctrl_if;
    import sr1_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_word;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;

    modport master (
        input  req_valid, req_write, req_word, req_addr, req_wdata, mem_do,
        output req_ready, rsp_valid, rsp_rdata, address, read, write, mem_di
    );

    modport slave (
        output req_valid, req_write, req_word, req_addr, req_wdata, mem_do,
        input  req_ready, rsp_valid, rsp_rdata, address, read, write, mem_di
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences core byte/word loads and stores into single-byte SR-1 memory strobes.
// Define MEM_WORD_EN to honour req_word (two-phase 16-bit accesses); otherwise byte only.
module mem_access_ctrl
    import sr1_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                mem_clk,
    input  logic                mem_reset_n,
    mem_access_ctrl_if.master   bus
);

    localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [7:0]        lo_q, lo_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] mem_di_q, mem_di_d;

    logic              more_bytes;
    logic              wait_done;

    assign more_bytes = req_q.word && !phase_q;
    assign wait_done  = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            address_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            mem_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            address_q   <= address_d;
            read_q      <= read_d;
            write_q     <= write_d;
            mem_di_q    <= mem_di_d;
        end
    end

`ifdef MEM_WORD_EN
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign phase_q = 1'b0;
`endif

    // Sequencing: a byte phase ends after its strobe (store) or after RD_LAT wait cycles (load).
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d     = ST_ISSUE;
                    phase_d     = 1'b0;
                    req_d.write = bus.req_write;
`ifdef MEM_WORD_EN
                    req_d.word  = bus.req_word;
`else
                    req_d.word  = 1'b0;
`endif
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (!req_q.write) begin
                    state_d = ST_WAIT;
                end else if (more_bytes) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (more_bytes) begin
                        state_d = ST_ISSUE;
                        phase_d = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        read_d      = 1'b0;
        write_d     = 1'b0;
        address_d   = address_q;
        mem_di_d    = mem_di_q;
        rsp_rdata_d = rsp_rdata_q;
        lo_d        = lo_q;
        if (state_d == ST_ISSUE) begin
            read_d    = !req_d.write;
            write_d   = req_d.write;
            address_d = phase_d ? (req_d.addr + 1'b1) : req_d.addr;
            mem_di_d  = phase_d ? req_d.wdata[15:8] : req_d.wdata[7:0];
        end
        if (wait_done) begin
            if (more_bytes) begin
                lo_d = bus.mem_do;
            end else if (req_q.word) begin
                rsp_rdata_d = {bus.mem_do, lo_q};
            end else begin
                rsp_rdata_d = {8'h00, bus.mem_do};
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.address   = address_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.mem_di    = mem_di_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level memory model.
// Follows MEM_WORD_EN the same way as the design.
module tb_mem_access_ctrl;

    localparam int RD_LAT = 1;
`ifdef MEM_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    logic mem_clk = 1'b0;
    logic mem_reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [15:0] last_rd = 16'h0000;

    always #5 mem_clk = ~mem_clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.RD_LAT(RD_LAT)) dut (
        .mem_clk     (mem_clk),
        .mem_reset_n (mem_reset_n),
        .bus         (bus)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 73) ^ (i >> 5) ^ 8'h5C);
    endfunction

    // Memory responder: registered BSRAM read, combinational MMIO window.
    logic [7:0] mem [0:32767];
    logic [7:0] bsram_q;
    logic       init_done = 1'b0;

    always @(posedge mem_clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else begin
            if (bus.write) mem[bus.address] <= bus.mem_di;
            if (bus.read) bsram_q <= mem[bus.address];
        end
    end

    assign bus.mem_do = (bus.address >= 15'h7FFC) ? mem[bus.address] : bsram_q;

    // Reference memory contents as seen by completed transactions.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_byte(input logic [14:0] x);
        return ref_mem.exists(int'(x)) ? ref_mem[int'(x)] : init_val(int'(x));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [14:0] a;
        logic [7:0]  d;
    } strobe_t;
    strobe_t sq[$];

    always @(negedge mem_clk) begin
        if (mon_en) begin
            chk("rw_excl", 32'(bus.read & bus.write), 32'd0);
            if (bus.read || bus.write) sq.push_back('{bus.write, bus.address, bus.mem_di});
        end
    end

    // Starts and ends at a negedge with the controller idle and ready.
    task automatic do_txn(input bit wr, input bit wd, input logic [14:0] a, input logic [15:0] wdat);
        int nb, lat, bi;
        logic [14:0] a1, ea;
        nb  = (wd && WORD_EN) ? 2 : 1;
        lat = 1 + nb * (1 + (wr ? 0 : RD_LAT));
        a1  = a + 15'd1;
        if (wr) begin
            ref_mem[int'(a)] = wdat[7:0];
            if (nb == 2) ref_mem[int'(a1)] = wdat[15:8];
        end else begin
            last_rd = (nb == 2) ? {ref_byte(a1), ref_byte(a)} : {8'h00, ref_byte(a)};
        end
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        sq.delete();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_word  = wd;
        bus.req_addr  = a;
        bus.req_wdata = wdat;
        for (int k = 1; k <= lat; k++) begin
            @(negedge mem_clk);
            if (k < lat) begin
                bus.req_valid = 1'($urandom);
                bus.req_write = 1'($urandom);
                bus.req_word  = 1'($urandom);
                bus.req_addr  = 15'($urandom);
                bus.req_wdata = 16'($urandom);
                bi = wr ? (k - 1) : (k - 1) / (1 + RD_LAT);
                ea = (bi != 0) ? a1 : a;
                chk("busy_rsp", 32'(bus.rsp_valid), 32'd0);
                chk("busy_ready", 32'(bus.req_ready), 32'd0);
                chk("busy_addr", 32'(bus.address), 32'(ea));
            end else begin
                bus.req_valid = 1'b0;
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_ready", 32'(bus.req_ready), 32'd0);
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(last_rd));
            end
        end
        chk("n_strobe", 32'(sq.size()), 32'(nb));
        for (int i = 0; i < nb && i < sq.size(); i++) begin
            chk("strb_kind", 32'(sq[i].wr), 32'(wr));
            chk("strb_addr", 32'(sq[i].a), 32'((i == 0) ? a : a1));
            if (wr) chk("strb_data", 32'(sq[i].d), 32'((i == 0) ? wdat[7:0] : wdat[15:8]));
        end
        @(negedge mem_clk);
        chk("after_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("after_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_read"}, 32'(bus.read), 32'd0);
        chk({tag, "_write"}, 32'(bus.write), 32'd0);
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_addr"}, 32'(bus.address), 32'd0);
        chk({tag, "_di"}, 32'(bus.mem_di), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [14:0] ra;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge mem_clk);
        chk_all_zero("rst");
        mem_reset_n = 1'b1;
        #1;
        chk("rel_ready_pre", 32'(bus.req_ready), 32'd0);
        @(negedge mem_clk);
        chk("rel_ready", 32'(bus.req_ready), 32'd1);
        mon_en = 1'b1;

        do_txn(1'b1, 1'b0, 15'h0123, 16'h005A);
        do_txn(1'b0, 1'b0, 15'h0123, 16'h0000);
        do_txn(1'b1, 1'b1, 15'h1000, 16'hBEEF);
        do_txn(1'b0, 1'b1, 15'h1000, 16'h0000);
        do_txn(1'b1, 1'b0, 15'h7FFF, 16'h0010);
        do_txn(1'b1, 1'b0, 15'h0000, 16'h0022);
        do_txn(1'b0, 1'b1, 15'h7FFF, 16'h0000);
        do_txn(1'b1, 1'b0, 15'h7FFE, 16'h00A5);
        do_txn(1'b0, 1'b0, 15'h7FFE, 16'h0000);

        // Reset dropped into the strobe cycle, then into the wait cycle.
        for (int rk = 1; rk <= 2; rk++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_word  = 1'b1;
            bus.req_addr  = 15'h1000;
            for (int k = 1; k <= rk; k++) @(negedge mem_clk);
            bus.req_valid = 1'b0;
            chk("mid_read", 32'(bus.read), 32'((rk == 1) ? 1 : 0));
            chk("mid_addr", 32'(bus.address), 32'h1000);
            mem_reset_n = 1'b0;
            #1;
            chk_all_zero("mid");
            last_rd = 16'h0000;
            repeat (2) begin
                @(negedge mem_clk);
                chk("mid_norsp", 32'(bus.rsp_valid), 32'd0);
            end
            mem_reset_n = 1'b1;
            @(negedge mem_clk);
            chk("mid_ready", 32'(bus.req_ready), 32'd1);
            do_txn(1'b0, 1'b0, 15'h0123, 16'h0000);
        end

        repeat (60) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      ra = 15'h7FFC + 15'($urandom_range(0, 3));
            else if (sel == 1) ra = 15'($urandom_range(0, 3));
            else               ra = 15'($urandom);
            do_txn(1'($urandom), 1'($urandom), ra, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
